// File: rtl/debounce_edge_if.sv
// Bundle of the filter's control inputs, debounced level, pulses and statistics.
interface debounce_edge_if #(
  parameter int unsigned EvtWidth = 8
);
  logic                en_i;
  logic                clear_i;
  logic                serial_i;
  logic                level_o;
  logic                rise_o;
  logic                fall_o;
  logic                busy_o;
  logic [EvtWidth-1:0] edge_cnt_o;
  logic [EvtWidth-1:0] glitch_cnt_o;

  // Driver side: the block feeding the filter and reading its results.
  modport master (
    output en_i, clear_i, serial_i,
    input  level_o, rise_o, fall_o, busy_o, edge_cnt_o, glitch_cnt_o
  );

  // Filter side.
  modport slave (
    input  en_i, clear_i, serial_i,
    output level_o, rise_o, fall_o, busy_o, edge_cnt_o, glitch_cnt_o
  );
endinterface

// File: rtl/debounce_edge.sv
// Glitch filter and edge detector for an already-synchronized level.
// A new level is accepted only after STABLE_CYCLES consecutive enabled samples differ from the
// current level; accepted edges produce one-cycle rise/fall pulses and bump a wrapping counter,
// aborted candidate runs bump a saturating glitch counter.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CntWidth      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1,
  parameter int unsigned EvtWidth      = 8,
  parameter logic        ResetValue    = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  debounce_edge_if.slave  io_bus
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(STABLE_CYCLES - 1);
  localparam logic [EvtWidth-1:0] EvtMax  = '1;

  // Run counter: zero means STABLE, non-zero means a candidate transition is PENDING.
  logic [CntWidth-1:0] r_cnt;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;
  logic [EvtWidth-1:0] r_edge_cnt;
  logic [EvtWidth-1:0] r_glitch_cnt;

  logic [CntWidth-1:0] w_cnt_d;
  logic                w_level_d;
  logic                w_rise_d;
  logic                w_fall_d;
  logic                w_accept;
  logic                w_abort;
  logic [EvtWidth-1:0] w_edge_cnt_d;
  logic [EvtWidth-1:0] w_glitch_cnt_d;

  // State register: run counter, debounced level and registered edge pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_level <= ResetValue;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_level <= w_level_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  // Next-state: disable drops the run, otherwise accept / extend / abort the candidate run.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_level_d = r_level;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    if (!io_bus.en_i) begin
      w_cnt_d = '0;
    end else if (io_bus.serial_i != r_level) begin
      if (r_cnt == LastCnt) begin
        w_accept  = 1'b1;
        w_level_d = io_bus.serial_i;
        w_cnt_d   = '0;
        w_rise_d  = io_bus.serial_i;
        w_fall_d  = ~io_bus.serial_i;
      end else begin
        w_cnt_d = r_cnt + CntWidth'(1);
      end
    end else if (r_cnt != '0) begin
      w_cnt_d = '0;
      w_abort = 1'b1;
    end
  end

  // Statistics next-state: clear wins over a coincident increment.
  always_comb begin
    w_edge_cnt_d   = r_edge_cnt;
    w_glitch_cnt_d = r_glitch_cnt;
    if (io_bus.clear_i) begin
      w_edge_cnt_d   = '0;
      w_glitch_cnt_d = '0;
    end else begin
      if (w_accept) begin
        w_edge_cnt_d = r_edge_cnt + EvtWidth'(1);
      end
      if (w_abort && (r_glitch_cnt != EvtMax)) begin
        w_glitch_cnt_d = r_glitch_cnt + EvtWidth'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_edge_cnt   <= '0;
      r_glitch_cnt <= '0;
    end else begin
      r_edge_cnt   <= w_edge_cnt_d;
      r_glitch_cnt <= w_glitch_cnt_d;
    end
  end

  // Outputs come straight from registers; busy is decoded from the run counter.
  always_comb begin
    io_bus.level_o      = r_level;
    io_bus.rise_o       = r_rise;
    io_bus.fall_o       = r_fall;
    io_bus.busy_o       = (r_cnt != '0);
    io_bus.edge_cnt_o   = r_edge_cnt;
    io_bus.glitch_cnt_o = r_glitch_cnt;
  end

endmodule
